led_breathe_pwm: RTL and testbench
==================================

// Module: led_breathe_pwm
// PURPOSE
//  Breathing-LED driver for the on-board RGB LED. A prescaled step tick ramps
//  a brightness level up, holds, ramps down and holds, repeating forever.
//  The level drives a free-running PWM comparator onto the active-low LED pins.
//  It is the LED output stage for free-running-counter blink logic: a smooth
//  fade replaces a raw counter bit on each pin.
// PARAMETERS
//  PWM_BITS      8      width of PWM counter and brightness level
//  PRESCALE_DIV  48000  CLK cycles per ramp step (>=2); 1 ms at 48 MHz
//  HOLD_STEPS    64     ramp steps spent in each hold state (>=1)
// PORTS
//  CLK     in   1         system clock
//  RST_N   in   1         asynchronous active-low reset
//  EN      in   1         1 = run; 0 = freeze ramp, LEDs off
//  COLOR   in   3         channel mask {B,G,R}; 1 = channel breathes
//  LED1    out  1         red, active-low (0 = lit)
//  LED2    out  1         green, active-low
//  LED3    out  1         blue, active-low
//  LEVEL   out  PWM_BITS  current brightness level (debug/observe)
// BEHAVIOUR
//  - Reset (RST_N=0, async): LED1..3=1, LEVEL=0, state=RISE, prescaler=0,
//    pwm_cnt=0, hold_cnt=0, duty regs=0, colour mask reg=0.
//  - pwm_cnt: +1 every CLK, wraps 2^PWM_BITS-1 -> 0. Runs regardless of EN.
//  - Prescaler: counts 0..PRESCALE_DIV-1 while EN=1. tick=1 for one cycle at
//    terminal count, then returns to 0. EN=0 clears it to 0; no tick.
//  - FSM (advances only on tick):
//    RISE:    LEVEL+1; when LEVEL==MAX (2^PWM_BITS-1) on tick -> HOLD_HI, hold_cnt=0
//    HOLD_HI: hold_cnt+1; at hold_cnt==HOLD_STEPS-1 -> FALL
//    FALL:    LEVEL-1; when LEVEL==0 on tick -> HOLD_LO, hold_cnt=0
//    HOLD_LO: hold_cnt+1; at hold_cnt==HOLD_STEPS-1 -> RISE
//    LEVEL saturates: never wraps past MAX or below 0.
//  - Duty latch: at pwm_cnt==2^PWM_BITS-1 (last cycle of the period),
//    sample COLOR into the mask reg and load duty_c = mask_c ? LEVEL : 0.
//    Duty and mask never change mid-period (glitch-free).
//  - Output (registered, 1-cycle latency): LEDn <= ~(EN & (pwm_cnt < duty_n)).
//    A duty of 0 gives always off. A duty of MAX gives on for MAX of 2^PWM_BITS
//    cycles, so it is never 100%.
//  - EN falling: LEDs=1 from the next edge. LEVEL, state and hold_cnt hold.
//    EN rising: the ramp resumes from the frozen point after a full PRESCALE_DIV.
//  - COLOR changes take effect only at the next period boundary.
//  - Mid-operation reset: all state returns to reset values immediately. The
//    ramp restarts from RISE/LEVEL 0 after release.
//  - Full triangle period = 2*(2^PWM_BITS-1+HOLD_STEPS)*PRESCALE_DIV cycles.
// TESTING (bench params: PWM_BITS=3, PRESCALE_DIV=4, HOLD_STEPS=2)
//  1 Reset: assert RST_N=0 asynchronously mid-ramp -> LED1..3=1, LEVEL=0
//    within the same cycle. Release with EN=1 -> first LEVEL=1 after 4 CLKs.
//  2 Ramp: EN=1, COLOR=3'b111 -> LEVEL goes 0..7 (one step per 4 CLKs), holds
//    7 for 8 CLKs, goes 7..0, holds 0 for 8 CLKs. Triangle period = 72 CLKs.
//  3 PWM: freeze LEVEL=5 (EN low then high at a boundary) -> each LED low
//    exactly 5 of every 8 CLKs. LEVEL=0 -> never low. LEVEL=7 -> low 7 of 8.
//  4 Mask: COLOR=3'b010 -> only LED2 toggles, LED1/LED3 stay 1. Switch COLOR
//    mid-period -> the change shows only after pwm_cnt wraps 7->0.
//  5 Enable: drop EN at LEVEL=4 for 20 CLKs -> LEDs=1 next cycle, LEVEL stays
//    4. Raise EN -> LEVEL=5 after 4 CLKs.
//  6 Saturation: run 3 full triangles -> LEVEL stays in [0,7] and never wraps.

Source files
------------

// File: rtl/led_breathe_pwm.sv
// Breathing-LED driver: a prescaled triangle ramp of brightness feeds a
// free-running PWM comparator onto three active-low RGB pins.
module led_breathe_pwm #(
  parameter int PWM_BITS     = 8,
  parameter int PRESCALE_DIV = 48000,
  parameter int HOLD_STEPS   = 64
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                EN,
  input  logic [2:0]          COLOR,
  output logic                LED1,
  output logic                LED2,
  output logic                LED3,
  output logic [PWM_BITS-1:0] LEVEL
);

  localparam int PW = (PRESCALE_DIV > 2) ? $clog2(PRESCALE_DIV) : 1;
  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  localparam logic [PWM_BITS-1:0] LMAX = '1;
  localparam logic [PWM_BITS-1:0] LMAX_M1 = LMAX - 1'b1;
  localparam logic [PWM_BITS-1:0] LONE = PWM_BITS'(1);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE_DIV - 1);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_STEPS - 1);

  typedef enum logic [1:0] {
    S_RISE,
    S_HOLD_HI,
    S_FALL,
    S_HOLD_LO
  } state_t;

  state_t                      r_state;
  state_t                      w_state_n;
  logic [PWM_BITS-1:0]         r_level;
  logic [PWM_BITS-1:0]         w_level_n;
  logic [HW-1:0]               r_hold;
  logic [HW-1:0]               w_hold_n;
  logic [PW-1:0]               r_presc;
  logic [PWM_BITS-1:0]         r_pwm;
  logic [2:0][PWM_BITS-1:0]    r_duty;
  logic [2:0]                  r_mask;
  logic [2:0]                  r_led;
  logic                        w_tick;
  logic                        w_wrap;
  logic [2:0]                  w_on;

  assign w_tick = EN && (r_presc == PMAX);
  assign w_wrap = (r_pwm == LMAX);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_presc <= '0;
    end else if (!EN || r_presc == PMAX) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // The edge step that reaches an end-stop also enters the hold, so each
  // half-triangle lasts exactly (MAX + HOLD_STEPS) ticks.
  always_comb begin
    w_state_n = r_state;
    w_level_n = r_level;
    w_hold_n  = r_hold;
    if (w_tick) begin
      unique case (r_state)
        S_RISE: begin
          if (r_level != LMAX) w_level_n = r_level + 1'b1;
          if (r_level >= LMAX_M1) begin
            w_state_n = S_HOLD_HI;
            w_hold_n  = '0;
          end
        end
        S_HOLD_HI: begin
          if (r_hold == HMAX) w_state_n = S_FALL;
          else w_hold_n = r_hold + 1'b1;
        end
        S_FALL: begin
          if (r_level != '0) w_level_n = r_level - 1'b1;
          if (r_level <= LONE) begin
            w_state_n = S_HOLD_LO;
            w_hold_n  = '0;
          end
        end
        S_HOLD_LO: begin
          if (r_hold == HMAX) w_state_n = S_RISE;
          else w_hold_n = r_hold + 1'b1;
        end
        default: w_state_n = S_RISE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_RISE;
      r_level <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_n;
      r_level <= w_level_n;
      r_hold  <= w_hold_n;
    end
  end

  // Duty and mask only reload on the last count so a period never glitches.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pwm  <= '0;
      r_duty <= '0;
      r_mask <= '0;
    end else begin
      r_pwm <= r_pwm + 1'b1;
      if (w_wrap) begin
        r_mask <= COLOR;
        for (int c = 0; c < 3; c++) begin
          r_duty[c] <= COLOR[c] ? r_level : '0;
        end
      end
    end
  end

  always_comb begin
    w_on = '0;
    for (int c = 0; c < 3; c++) begin
      w_on[c] = EN && r_mask[c] && (r_pwm < r_duty[c]);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_led <= 3'b111;
    end else begin
      r_led <= ~w_on;
    end
  end

  assign LED1  = r_led[0];
  assign LED2  = r_led[1];
  assign LED3  = r_led[2];
  assign LEVEL = r_level;

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Bench for led_breathe_pwm: directed steps plus random EN/COLOR activity,
// checked each cycle against a tick-count based triangle model.
module tb_led_breathe_pwm;

  localparam int PB   = 3;
  localparam int DIV  = 4;
  localparam int HOLD = 2;
  localparam int M    = (1 << PB) - 1;
  localparam int NPER = 1 << PB;
  localparam int TPER = 2 * (M + HOLD);

  logic          CLK;
  logic          RST_N;
  logic          EN;
  logic [2:0]    COLOR;
  logic          LED1;
  logic          LED2;
  logic          LED3;
  logic [PB-1:0] LEVEL;

  int checks;
  int failures;
  bit cmp_on;

  int m_cyc;
  int m_run;
  int m_ticks;
  int m_duty[3];
  bit [2:0] m_led;

  led_breathe_pwm #(
    .PWM_BITS    (PB),
    .PRESCALE_DIV(DIV),
    .HOLD_STEPS  (HOLD)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .EN   (EN),
    .COLOR(COLOR),
    .LED1 (LED1),
    .LED2 (LED2),
    .LED3 (LED3),
    .LEVEL(LEVEL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Brightness after t ramp ticks: triangle of period TPER ticks.
  function automatic int lvl_of(input int t);
    int p;
    p = t % TPER;
    if (p <= M) return p;
    if (p <= M + HOLD) return M;
    if (p <= 2 * M + HOLD) return 2 * M + HOLD - p;
    return 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc   = 0;
    m_run   = 0;
    m_ticks = 0;
    for (int c = 0; c < 3; c++) m_duty[c] = 0;
    m_led = 3'b111;
  endtask

  task automatic model_edge(input bit en, input bit [2:0] col);
    int pc;
    int lv;
    pc = m_cyc % NPER;
    lv = lvl_of(m_ticks);
    for (int c = 0; c < 3; c++) m_led[c] = !(en && pc < m_duty[c]);
    if (pc == NPER - 1) begin
      for (int c = 0; c < 3; c++) m_duty[c] = col[c] ? lv : 0;
    end
    if (en) begin
      m_run++;
      if (m_run == DIV) begin
        m_run = 0;
        m_ticks++;
      end
    end else begin
      m_run = 0;
    end
    m_cyc++;
  endtask

  task automatic cyc();
    @(posedge CLK);
    if (RST_N) model_edge(EN, COLOR);
    #1;
    if (cmp_on) begin
      chk("level_model", int'(LEVEL), lvl_of(m_ticks));
      chk("leds_model", int'({LED3, LED2, LED1}), int'(m_led));
    end
  endtask

  task automatic pwm_window(input int target);
    int guard;
    int low[3];
    guard = 0;
    while (lvl_of(m_ticks) != target && guard < 4 * TPER * DIV) begin
      cyc();
      guard++;
    end
    chk("pwm_reach_level", int'(LEVEL), target);
    EN = 1'b0;
    guard = 0;
    do begin
      cyc();
      guard++;
    end while (m_cyc % NPER != 0 && guard < 2 * NPER);
    chk("pwm_frozen_level", int'(LEVEL), target);
    EN = 1'b1;
    for (int c = 0; c < 3; c++) low[c] = 0;
    for (int i = 0; i < NPER; i++) begin
      cyc();
      if (!LED1) low[0]++;
      if (!LED2) low[1]++;
      if (!LED3) low[2]++;
    end
    chk("pwm_low_led1", low[0], target);
    chk("pwm_low_led2", low[1], target);
    chk("pwm_low_led3", low[2], target);
  endtask

  initial begin
    int guard;
    int prev;
    int cnt1;
    int cnt2;
    int cnt3;
    int hist[$];

    checks   = 0;
    failures = 0;
    cmp_on   = 1'b0;
    RST_N    = 1'b0;
    EN       = 1'b0;
    COLOR    = 3'b000;
    model_reset();

    repeat (3) @(posedge CLK);
    #1;
    chk("reset_level", int'(LEVEL), 0);
    chk("reset_leds", int'({LED3, LED2, LED1}), 7);

    RST_N  = 1'b1;
    EN     = 1'b1;
    COLOR  = 3'b111;
    cmp_on = 1'b1;
    repeat (3) cyc();
    chk("first_step_pre", int'(LEVEL), 0);
    cyc();
    chk("first_step", int'(LEVEL), 1);

    // Two full triangles with directed landmarks and periodicity.
    hist.push_back(int'(LEVEL));
    for (int i = 5; i <= 4 + 2 * 72; i++) begin
      cyc();
      hist.push_back(int'(LEVEL));
      if (i == 28) chk("ramp_peak", int'(LEVEL), 7);
      if (i == 40) chk("ramp_first_fall", int'(LEVEL), 6);
      if (i == 64) chk("ramp_bottom", int'(LEVEL), 0);
      if (i == 76) chk("ramp_restart", int'(LEVEL), 1);
    end
    for (int i = 0; i < 72; i += 7) begin
      chk("triangle_period", hist[i + 72], hist[i]);
    end

    pwm_window(5);
    pwm_window(7);
    pwm_window(0);

    // Colour mask switched mid-period.
    guard = 0;
    while (!(m_cyc % NPER == 3 && (m_ticks % TPER) inside {[2 : 4]})
           && guard < 4 * TPER * DIV) begin
      cyc();
      guard++;
    end
    COLOR = 3'b010;
    guard = 0;
    do begin
      cyc();
      guard++;
    end while (m_cyc % NPER != 0 && guard < 2 * NPER);
    cnt1 = 0;
    cnt2 = 0;
    cnt3 = 0;
    for (int i = 0; i < 2 * NPER; i++) begin
      cyc();
      if (!LED1) cnt1++;
      if (!LED2) cnt2++;
      if (!LED3) cnt3++;
    end
    chk("mask_led1_off", cnt1, 0);
    chk("mask_led3_off", cnt3, 0);
    chk("mask_led2_toggles", int'(cnt2 > 0), 1);
    COLOR = 3'b111;

    // Asynchronous reset between clock edges.
    cyc();
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_rst_level", int'(LEVEL), 0);
    chk("async_rst_leds", int'({LED3, LED2, LED1}), 7);
    model_reset();
    cmp_on = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N  = 1'b1;
    cmp_on = 1'b1;

    // Enable freeze at LEVEL 4.
    repeat (16) cyc();
    chk("en_level4", int'(LEVEL), 4);
    EN = 1'b0;
    cyc();
    chk("en_off_leds", int'({LED3, LED2, LED1}), 7);
    repeat (19) cyc();
    chk("en_frozen_level", int'(LEVEL), 4);
    EN = 1'b1;
    repeat (3) cyc();
    chk("en_resume_wait", int'(LEVEL), 4);
    cyc();
    chk("en_resume_step", int'(LEVEL), 5);

    // Random EN drops and colour changes over several triangles.
    prev = int'(LEVEL);
    for (int i = 0; i < 3 * 72 + 120; i++) begin
      if ($urandom_range(15) == 0) COLOR = 3'($urandom_range(7));
      if ($urandom_range(31) == 0) EN = 1'b0;
      else if (!EN && $urandom_range(3) == 0) EN = 1'b1;
      cyc();
      chk("no_wrap", int'((int'(LEVEL) - prev) inside {[-1 : 1]}), 1);
      prev = int'(LEVEL);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
